// File: rtl/fifo_uart_tx.sv
// UART transmitter on the FIFO read side: pops one byte per frame and serializes it as
// start, Data_width data bits LSB-first, optional parity, stop. Clk is the bit clock.
module fifo_uart_tx #(
    parameter int unsigned Data_width = 8
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Rempty,
    input  logic [Data_width-1:0] Rdata,
    input  logic                  Par_en,
    input  logic                  Par_typ,
    output logic                  Rinc,
    output logic                  Tx_out,
    output logic                  Busy
);

    localparam int unsigned CntW = (Data_width > 1) ? $clog2(Data_width) : 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_e;

    state_e                state_q, state_d;
    logic [Data_width-1:0] shift_q, shift_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  par_en_q, par_en_d;
    logic                  par_bit_q, par_bit_d;
    logic                  tx_q, tx_d;
    logic                  busy_q, busy_d;
    logic                  rinc_q, rinc_d;
    logic                  load;

    // Next-state and next-output logic; outputs are the values for the cycle after the edge.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        cnt_d     = cnt_q;
        par_en_d  = par_en_q;
        par_bit_d = par_bit_q;
        tx_d      = tx_q;
        busy_d    = busy_q;
        rinc_d    = 1'b0;
        load      = 1'b0;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                load   = ~Rempty;
            end
            START: begin
                state_d = DATA;
                tx_d    = shift_q[0];
                shift_d = shift_q >> 1;
                cnt_d   = '0;
            end
            DATA: begin
                if (cnt_q == CntW'(Data_width - 1)) begin
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = par_bit_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end
                end else begin
                    tx_d    = shift_q[0];
                    shift_d = shift_q >> 1;
                    cnt_d   = cnt_q + CntW'(1);
                end
            end
            PARITY: begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
            STOP: begin
                // Back-to-back frames: reload directly from the stop bit with no idle gap.
                if (!Rempty) begin
                    load = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        if (load) begin
            state_d   = START;
            shift_d   = Rdata;
            cnt_d     = '0;
            par_en_d  = Par_en;
            par_bit_d = Par_typ ? ~^Rdata : ^Rdata;
            tx_d      = 1'b0;
            busy_d    = 1'b1;
            rinc_d    = 1'b1;
        end
    end

    // State and registered outputs; reset aborts any frame in flight.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            par_en_q  <= 1'b0;
            par_bit_q <= 1'b0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            rinc_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            cnt_q     <= cnt_d;
            par_en_q  <= par_en_d;
            par_bit_q <= par_bit_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            rinc_q    <= rinc_d;
        end
    end

    assign Rinc   = rinc_q;
    assign Tx_out = tx_q;
    assign Busy   = busy_q;

endmodule
